// File: rtl/approx_seq_mult.sv
// Iterative shift-add unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH) whose accumulator
// adder runs the low k columns on the approximate cell and the rest on exact full adders.
module approx_seq_mult #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned KW    = $clog2(2*WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [KW-1:0]      approx_k,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [KW-1:0]      out_k
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [KW-1:0] KMAX  = KW'(PW);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   step;

  logic [PW-1:0]   sum;
  logic            c;

  // Hybrid ripple adder: approximate cell below column k_q, exact above; top carry dropped.
  always_comb begin
    sum = '0;
    c   = 1'b0;
    for (int j = 0; j < PW; j++) begin
      if (KW'(j) < k_q) begin
        sum[j] = ~c;
        c      = c & (acc[j] | a_sh[j]);
      end else begin
        sum[j] = acc[j] ^ a_sh[j] ^ c;
        c      = (acc[j] & a_sh[j]) | (c & (acc[j] ^ a_sh[j]));
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_k     <= '0;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      k_q       <= '0;
      step      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= BUSY;
            in_ready <= 1'b0;
            a_sh     <= PW'(in_a);
            b_sh     <= in_b;
            k_q      <= (approx_k > KMAX) ? KMAX : approx_k;
            acc      <= '0;
            step     <= '0;
          end
        end
        BUSY: begin
          if (step == STEPS) begin
            state     <= DONE;
            out_p     <= acc;
            out_k     <= k_q;
            out_valid <= 1'b1;
          end else begin
            if (b_sh[0]) acc <= sum;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            step <= step + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_seq_mult.sv
// Directed and model-checked bench for approx_seq_mult at WIDTH=8.
module tb_approx_seq_mult;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned KW = $clog2(2*W+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [KW-1:0] approx_k = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_p;
  logic [KW-1:0] out_k;

  int errors = 0;
  int checks = 0;

  approx_seq_mult #(.WIDTH(W), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .approx_k(approx_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_k(out_k)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference adder: any add with k>=1 leaves low k bits set and no carry into column k.
  function automatic logic [PW-1:0] addk_ref(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                             input int k);
    logic [31:0] mask;
    logic [31:0] up;
    if (k == 0) return x + y;
    mask = (k >= 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
    up   = ((32'(x) >> k) + (32'(y) >> k)) << k;
    return PW'(up | mask);
  endfunction

  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input int k);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) acc = addk_ref(acc, PW'(a) << i, k);
    return acc;
  endfunction

  // One full transaction: accept, latency, result, back-pressure hold, release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [KW-1:0] k,
                        input int stall, input logic [PW-1:0] exp_p, input logic [KW-1:0] exp_k);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; approx_k = k; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); approx_k = KW'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(W + 1));
    chk("out_p", 64'(out_p), 64'(exp_p));
    chk("out_k", 64'(out_k), 64'(exp_k));
    chk("busy_ready", 64'(in_ready), 64'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_p", 64'(out_p), 64'(exp_p));
      chk("stall_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_ready", 64'(in_ready), 64'd1);
    chk("release_p", 64'(out_p), 64'(exp_p));
  endtask

  initial begin
    logic [W-1:0]  ra, rb;
    logic [KW-1:0] rk;
    int            ek;

    #12;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_p", 64'(out_p), 64'd0);
    chk("rst_k", 64'(out_k), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd13, 8'd11, 5'd0, 0, 16'd143, 5'd0);
    run_op(8'd255, 8'd255, 5'd0, 0, 16'd65025, 5'd0);
    run_op(8'd13, 8'd11, 5'd4, 0, 16'h007F, 5'd4);
    run_op(8'd13, 8'd0, 5'd4, 0, 16'h0000, 5'd4);
    run_op(8'd1, 8'd1, 5'd20, 0, 16'hFFFF, 5'd16);
    run_op(8'd200, 8'd3, 5'd16, 0, 16'hFFFF, 5'd16);
    run_op(8'd13, 8'd11, 5'd0, 5, 16'd143, 5'd0);

    // Abort in the middle of BUSY.
    @(negedge clk);
    in_a = 8'd77; in_b = 8'd99; approx_k = 5'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_p", 64'(out_p), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end
    run_op(8'd3, 8'd5, 5'd0, 0, 16'd15, 5'd0);

    // Random sweep against the reference adder model.
    for (int t = 0; t < 1000; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rk = KW'($urandom_range(0, 20));
      ek = (int'(rk) > PW) ? PW : int'(rk);
      run_op(ra, rb, rk, $urandom_range(0, 3), model(ra, rb, ek), KW'(ek));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_seq_mult.md
Name: approx_seq_mult

Overview:
- Parametrised, handshaked, iterative shift-add unsigned multiplier, N×N → 2N.
- The accumulator adder is hybrid. The low K result columns use the team's approximate cell (S = ~Cin, Cout = Cin & (X|Y)); the remaining columns use exact full adders.
- K is selected per operation at run time, so one instance covers exact and approximate products.
- Used as the sequential, area-lean member of the approximate multiplier library for accuracy/area sweeps against the combinational Dadda variants.

Parameters:
- WIDTH, 8, operand width N (≥2); product width is 2N.
- KW, $clog2(2*WIDTH+1), width of the approx_k input.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- approx_k  in  KW  number of approximate low columns for this operation.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- out_p  out  2*WIDTH  product.
- out_k  out  KW  effective K used (after clamping).

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; out_p=0; out_k=0; acc=0; step counter=0. Release is synchronous to clk.
- States: IDLE, BUSY, DONE.
- in_ready=1 only in IDLE.
- IDLE → BUSY on a clk edge with in_valid & in_ready. At that edge:
  - capture a, b;
  - capture k = min(approx_k, 2N);
  - acc=0, i=0.
- BUSY: exactly N cycles, one step per cycle, i = 0..N-1.
  - Step i: if b[i]=1 then acc ← addk(acc, a<<i), else acc unchanged.
  - After step N-1 → DONE. out_p ← acc, out_k ← k, out_valid=1.
  - Latency: out_valid rises N+1 edges after the accept edge.
- addk(x, y), 2N bits, carry into column 0 = 0:
  - column j<k: s_j = ~c_j; c_{j+1} = c_j & (x_j | y_j).
  - column j≥k: exact full adder.
  - Carry out of column 2N-1 is dropped.
  - Consequence: with k≥1, every performed add yields low k bits = 1 and zero carry into column k.
- k=0 gives an exact product.
- k=2N: result is all-ones if b≠0, 0 if b=0.
- DONE:
  - out_p, out_k hold stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1 → IDLE, out_valid=0. out_p keeps its last value.
- Inputs are ignored outside IDLE; in_valid during BUSY/DONE is not lost but is not sampled until IDLE.
- No back-to-back overlap: the next accept is at the earliest the edge after the DONE→IDLE transition.
- rst_n low mid-BUSY or mid-DONE: immediate abort to reset values. The pending product is discarded and no out_valid is produced.
- in_a/in_b/approx_k changing after the accept edge has no effect on the current operation.
- approx_k > 2N is clamped; out_k reports the clamped value.

Test Plan:
- Exact mode, N=8: a=13, b=11, k=0 → out_p=143, out_k=0, out_valid 9 edges after accept. Also a=255, b=255, k=0 → 65025.
- Approx mode, N=8: a=13, b=11, k=4 → out_p=127 (0x007F). Also a=13, b=0, k=4 → out_p=0 (no adds performed).
- Clamp and all-approx: a=1, b=1, approx_k=20 → out_k=16, out_p=0xFFFF.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → out_p stable, in_ready=0 throughout. Then out_ready=1 → in_ready=1 on the next cycle and a new accept succeeds.
- Reset mid-operation: assert rst_n=0 at step 3 of BUSY → immediately in_ready=1, out_valid=0, out_p=0. A new request (a=3, b=5, k=0) then yields 15.
- Randomised sweep: 1000 random (a, b, k) with random out_ready stalls, checked against a bit-accurate addk reference model. Every accepted request produces exactly one product, in order.
